// File: rtl/block_ram_pkg.sv
// Shared decompressor memory parameters: default geometry of the lane-addressed
// block RAM and of its 64-bit debug variant.
package block_ram_pkg;

  // Default geometry: 512 words of 8 lanes, each lane 8 data bits + 1 valid flag.
  localparam int BRAM_ADDR_W    = 9;
  localparam int BRAM_NUM_BYTES = 8;
  localparam int BRAM_BYTE_W    = 9;

  // The debug memory is the same block with plain 8-bit lanes (64-bit words).
  localparam int DBG_BYTE_W     = 8;

  // Width of one memory word for a given lane count and lane width.
  function automatic int word_width(input int num_bytes, input int byte_w);
    return num_bytes * byte_w;
  endfunction

endpackage

// File: rtl/block_ram.sv
// Simple dual-port block RAM: one byte-lane-masked write port, one registered
// read port, both on clk. Reads are read-first on address collision. Lanes are
// opaque; the block never looks inside them.
module block_ram
  import block_ram_pkg::*;
#(
  parameter int ADDR_W    = BRAM_ADDR_W,
  parameter int NUM_BYTES = BRAM_NUM_BYTES,
  parameter int BYTE_W    = BRAM_BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [NUM_BYTES-1:0]        wea,
  input  logic [ADDR_W-1:0]           addra,
  input  logic [NUM_BYTES*BYTE_W-1:0] dina,
  input  logic                        enb,
  input  logic [ADDR_W-1:0]           addrb,
  output logic [NUM_BYTES*BYTE_W-1:0] doutb
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = word_width(NUM_BYTES, BYTE_W);

  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] word_t;

  // Storage starts zeroed at configuration; reset never touches it, so the
  // external clean sequence stays in charge of clearing contents.
  word_t mem [DEPTH] = '{default: '0};

  logic [NUM_BYTES-1:0] lane_we_d;
  word_t                dina_w;
  word_t                doutb_d;
  word_t                doutb_q;

  assign dina_w = word_t'(dina);

  // Per-lane write strobes: the port enable gates every lane.
  always_comb begin
    lane_we_d = '0;
    if (ena) begin
      lane_we_d = wea;
    end
  end

  // Next read data: sample the addressed word when enabled, otherwise hold.
  // mem is read before the same-edge write lands, which gives read-first.
  always_comb begin
    doutb_d = doutb_q;
    if (enb) begin
      doutb_d = mem[addrb];
    end
  end

  // Output register (async clear) and lane-masked memory write; writes are
  // held off for as long as reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutb_q <= '0;
    end else begin
      doutb_q <= doutb_d;
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (lane_we_d[i]) begin
          mem[addra][i] <= dina_w[i];
        end
      end
    end
  end

  assign doutb = WORD_W'(doutb_q);

endmodule

// File: tb/tb_block_ram.sv
// Self-checking bench for block_ram: directed cases followed by randomized
// traffic, all compared against a word-array reference model.
module tb_block_ram;

  localparam int AW    = 9;
  localparam int NB    = 8;
  localparam int BW    = 9;
  localparam int W     = NB * BW;
  localparam int DEPTH = 2 ** AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic [NB-1:0]   wea;
  logic [AW-1:0]   addra;
  logic [W-1:0]    dina;
  logic            enb;
  logic [AW-1:0]   addrb;
  logic [W-1:0]    doutb;

  logic [W-1:0]    ref_mem [DEPTH];
  logic [W-1:0]    exp_dout;
  int              tests = 0;
  int              fails = 0;

  logic [W-1:0]    w0;
  logic [W-1:0]    w_part;
  logic [W-1:0]    w_hi;
  logic [W-1:0]    w_lo;
  logic [W-1:0]    ones;

  always #5 clk = ~clk;

  block_ram #(.ADDR_W(AW), .NUM_BYTES(NB), .BYTE_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then
  // move 1ns past the edge so outputs can be sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_dout = '0;
    end else begin
      if (enb) exp_dout = ref_mem[addrb];
      if (ena) begin
        for (int i = 0; i < NB; i++) begin
          if (wea[i]) ref_mem[addra][i*BW +: BW] = dina[i*BW +: BW];
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    exp_dout = '0;
    ones     = '1;
    rst_n = 1'b0; ena = 1'b0; wea = '0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;

    // Reset state
    tick();
    tick();
    check("reset_dout", doutb, '0);
    rst_n = 1'b1;

    // Unwritten word reads zero
    enb = 1'b1; addrb = 9'd3;
    tick();
    check("init_zero", doutb, '0);

    // Full write then read
    w0 = 72'h1_23_45_67_89_AB_CD_EF_01;
    enb = 1'b0; ena = 1'b1; wea = 8'hFF; addra = 9'd5; dina = w0;
    tick();
    ena = 1'b0; enb = 1'b1; addrb = 9'd5;
    tick();
    check("full_write", doutb, w0);

    // Partial write: lanes 0-3 all ones, lanes 4-7 untouched
    enb = 1'b0; ena = 1'b1; wea = 8'h0F; addra = 9'd5; dina = ones;
    tick();
    ena = 1'b0; enb = 1'b1; addrb = 9'd5;
    tick();
    w_part = {w0[71:36], 36'hF_FFFF_FFFF};
    check("partial_write", doutb, w_part);

    // Collision: read-first, new data on the following read
    ena = 1'b1; wea = 8'hFF; addra = 9'd7; dina = ones; enb = 1'b1; addrb = 9'd7;
    tick();
    check("collide_old", doutb, '0);
    ena = 1'b0;
    tick();
    check("collide_new", doutb, ones);

    // ena=0 blocks writes, enb=0 holds the output
    ena = 1'b0; wea = 8'hFF; addra = 9'd5; dina = 72'hAA_5555_AAAA_5555_AAAA; enb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_dout", doutb, ones);
    end
    enb = 1'b1; addrb = 9'd5;
    tick();
    check("ena_off", doutb, w_part);

    // Boundary words 511 and 0 are distinct
    w_hi = 72'hDE_ADBE_EF01_2345_6789;
    w_lo = 72'h13_579B_DF02_468A_CE0F;
    enb = 1'b0; ena = 1'b1; wea = 8'hFF; addra = 9'd511; dina = w_hi;
    tick();
    addra = 9'd0; dina = w_lo;
    tick();
    ena = 1'b0; enb = 1'b1; addrb = 9'd511;
    tick();
    check("bound_511", doutb, w_hi);
    addrb = 9'd0;
    tick();
    check("bound_0", doutb, w_lo);

    // Independent write and read at different addresses on one edge
    ena = 1'b1; wea = 8'hFF; addra = 9'd10; dina = w_hi ^ w_lo; enb = 1'b1; addrb = 9'd5;
    tick();
    check("indep_read", doutb, w_part);
    ena = 1'b0; addrb = 9'd10;
    tick();
    check("indep_write", doutb, w_hi ^ w_lo);

    // Asynchronous reset clears output mid-cycle; memory survives, writes blocked
    addrb = 9'd511;
    tick();
    check("pre_reset", doutb, w_hi);
    #2;
    rst_n = 1'b0;
    #1;
    exp_dout = '0;
    check("async_reset", doutb, '0);
    ena = 1'b1; wea = 8'hFF; addra = 9'd511; dina = 72'h0F_0F0F_0F0F_0F0F_0F0F;
    tick();
    check("reset_hold", doutb, '0);
    ena = 1'b0; rst_n = 1'b1; addrb = 9'd511;
    tick();
    check("mem_kept", doutb, w_hi);

    // Randomized traffic against the model, small address pool for collisions
    for (int n = 0; n < 400; n++) begin
      ena   = ($urandom_range(0, 3) != 0);
      enb   = ($urandom_range(0, 3) != 0);
      wea   = NB'($urandom);
      dina  = {8'($urandom), 32'($urandom), 32'($urandom)};
      addra = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 9'd504 : 9'd0));
      addrb = ($urandom_range(0, 2) == 0) ? addra : AW'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 9'd504 : 9'd0));
      tick();
      check("random", doutb, exp_dout);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
